// File: rtl/fpu_pkg.sv
// Shared types, constants and helpers for the floating-point datapath blocks.
package fpu_pkg;

   // Operand classes produced by the input classifier
   typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;

   // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   // Widest word the canonical-NaN builder can describe
   localparam int NAN_MAX_W = 128;

   // Exponent bias for a given exponent field width
   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set
   function automatic logic [NAN_MAX_W-1:0] canon_nan(input int exp_w, input int man_w);
      logic [NAN_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < exp_w; i++) begin
         r[man_w + i] = 1'b1;
      end
      r[man_w - 1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational operand classifier: class, sign, effective exponent and significand.
module fpu_classify
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W:0] x,
   output fp_class_e            cls,
   output logic                 sign,
   output logic [EXP_W-1:0]     exp_eff,
   output logic [MAN_W:0]       sig
);

   logic [EXP_W-1:0] exp_raw;
   logic [MAN_W-1:0] man;

   assign sign    = x[EXP_W+MAN_W];
   assign exp_raw = x[MAN_W +: EXP_W];
   assign man     = x[MAN_W-1:0];

   // Decode the class; subnormals report exponent 1 and drop the hidden bit
   always_comb begin
      cls     = NORM;
      exp_eff = exp_raw;
      sig     = {1'b1, man};
      if (exp_raw == '0) begin
         exp_eff = EXP_W'(1);
         sig     = {1'b0, man};
         cls     = (man == '0) ? ZERO : SUB;
      end else if (exp_raw == '1) begin
         if (man == '0) begin
            cls = INF;
         end else if (man[MAN_W-1]) begin
            cls = QNAN;
         end else begin
            cls = SNAN;
         end
      end
   end

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage IEEE-style multiplier: classify/exponent, multiply, normalise/round/pack.
module fmul_pipe
   import fpu_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int FTZ   = 1,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] s,
   input  logic [EXP_W+MAN_W:0] t,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] d,
   output logic [TAG_W-1:0]     out_tag,
   output logic [3:0]           flags
);

   localparam int W       = 1 + EXP_W + MAN_W;
   localparam int SW      = MAN_W + 1;
   localparam int PW      = 2 * SW;
   localparam int EW      = EXP_W + 2;
   localparam int EXP_MAX = (1 << EXP_W) - 1;
   localparam logic signed [EW-1:0]  BIAS     = EW'(fp_bias(EXP_W));
   localparam logic [NAN_MAX_W-1:0]  NAN_FULL = canon_nan(EXP_W, MAN_W);
   localparam logic [W-1:0]          NAN_WORD = NAN_FULL[W-1:0];

   logic en;

   fp_class_e        cls_s, cls_t, ca, cb;
   logic             sgn_s, sgn_t, sign_c, nan_a, nan_b;
   logic [EXP_W-1:0] ex_s, ex_t;
   logic [MAN_W:0]   sig_s, sig_t;
   logic             spec_c;
   logic [W-1:0]     spec_word_c;
   logic [3:0]       spec_flags_c;
   logic signed [EW-1:0] exp_sum_c;

   logic                 v1, sign1, spec1;
   logic [TAG_W-1:0]     tag1;
   logic [W-1:0]         spec_word1;
   logic [3:0]           spec_flags1;
   logic signed [EW-1:0] exp1;
   logic [MAN_W:0]       sig_a1, sig_b1;

   logic                 v2, sign2, spec2;
   logic [TAG_W-1:0]     tag2;
   logic [W-1:0]         spec_word2;
   logic [3:0]           spec_flags2;
   logic signed [EW-1:0] exp2;
   logic [PW-1:0]        prod2;

   int                   lz, sh;
   logic                 found, tiny, lost, g, r, st, inc, inexact, ovf;
   logic signed [31:0]   e;
   logic [PW-1:0]        pn, q;
   logic [2*PW-1:0]      ext;
   logic [MAN_W-1:0]     frac;
   logic [EXP_W-1:0]     exp_field;
   logic [EXP_W+MAN_W:0] rounded;
   logic [EXP_W:0]       rexp;
   logic [W-1:0]         res_c;
   logic [3:0]           res_flags_c;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_s (
      .x(s), .cls(cls_s), .sign(sgn_s), .exp_eff(ex_s), .sig(sig_s)
   );

   fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_t (
      .x(t), .cls(cls_t), .sign(sgn_t), .exp_eff(ex_t), .sig(sig_t)
   );

   assign ca     = (FTZ != 0 && cls_s == SUB) ? ZERO : cls_s;
   assign cb     = (FTZ != 0 && cls_t == SUB) ? ZERO : cls_t;
   assign sign_c = sgn_s ^ sgn_t;
   assign nan_a  = (ca == QNAN) || (ca == SNAN);
   assign nan_b  = (cb == QNAN) || (cb == SNAN);

   // S1: resolve special operands up front and form the biased exponent sum
   always_comb begin
      spec_c       = 1'b1;
      spec_word_c  = '0;
      spec_flags_c = '0;
      exp_sum_c    = $signed({2'b00, ex_s}) + $signed({2'b00, ex_t}) - BIAS;
      if (nan_a || nan_b) begin
         spec_word_c                = NAN_WORD;
         spec_flags_c[FLAG_INVALID] = (ca == SNAN) || (cb == SNAN);
      end else if ((ca == INF && cb == ZERO) || (ca == ZERO && cb == INF)) begin
         spec_word_c                = NAN_WORD;
         spec_flags_c[FLAG_INVALID] = 1'b1;
      end else if (ca == INF || cb == INF) begin
         spec_word_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (ca == ZERO || cb == ZERO) begin
         spec_word_c = {sign_c, {(EXP_W+MAN_W){1'b0}}};
      end else begin
         spec_c = 1'b0;
      end
   end

   // S1 register: every stage holds when the output is stalled
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1          <= 1'b0;
         tag1        <= '0;
         sign1       <= 1'b0;
         spec1       <= 1'b0;
         spec_word1  <= '0;
         spec_flags1 <= '0;
         exp1        <= '0;
         sig_a1      <= '0;
         sig_b1      <= '0;
      end else if (en) begin
         v1          <= in_valid;
         tag1        <= in_tag;
         sign1       <= sign_c;
         spec1       <= spec_c;
         spec_word1  <= spec_word_c;
         spec_flags1 <= spec_flags_c;
         exp1        <= exp_sum_c;
         sig_a1      <= sig_s;
         sig_b1      <= sig_t;
      end
   end

   // S2 register: full-width significand product
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v2          <= 1'b0;
         tag2        <= '0;
         sign2       <= 1'b0;
         spec2       <= 1'b0;
         spec_word2  <= '0;
         spec_flags2 <= '0;
         exp2        <= '0;
         prod2       <= '0;
      end else if (en) begin
         v2          <= v1;
         tag2        <= tag1;
         sign2       <= sign1;
         spec2       <= spec1;
         spec_word2  <= spec_word1;
         spec_flags2 <= spec_flags1;
         exp2        <= exp1;
         prod2       <= PW'(sig_a1) * PW'(sig_b1);
      end
   end

   // S3: normalise on the leading one, denormalise tiny results, round to nearest even
   always_comb begin
      lz    = 0;
      found = 1'b0;
      for (int i = PW - 1; i >= 0; i--) begin
         if (!found) begin
            if (prod2[i]) begin
               found = 1'b1;
            end else begin
               lz = lz + 1;
            end
         end
      end
      pn   = prod2 << lz;
      e    = 32'(exp2) + 32'sd1 - lz;
      tiny = (e < 32'sd1);
      sh   = 0;
      if (tiny) begin
         sh = 1 - e;
         if (sh > MAN_W + 2) begin
            sh = MAN_W + 2;
         end
      end
      ext     = {pn, {PW{1'b0}}} >> sh;
      q       = ext[2*PW-1:PW];
      lost    = |ext[PW-1:0];
      frac    = q[PW-2 -: MAN_W];
      g       = q[PW-2-MAN_W];
      r       = q[PW-3-MAN_W];
      st      = (|q[PW-4-MAN_W:0]) | lost;
      inc     = g & (r | st | frac[0]);
      inexact = g | r | st;
      // a denormalised value carries its (zero) hidden bit in the exponent lsb,
      // so a rounding carry promotes it to the minimum normal naturally
      exp_field = tiny ? {{(EXP_W-1){1'b0}}, q[PW-1]} : e[EXP_W-1:0];
      rounded   = {1'b0, exp_field, frac} + {{(EXP_W+MAN_W){1'b0}}, inc};
      rexp      = rounded[MAN_W +: EXP_W+1];
      ovf       = (e >= EXP_MAX) || (rexp >= (EXP_W+1)'(EXP_MAX));

      res_c       = {sign2, rounded[EXP_W+MAN_W-1:0]};
      res_flags_c = '0;
      if (spec2) begin
         res_c       = spec_word2;
         res_flags_c = spec_flags2;
      end else if (ovf) begin
         res_c                       = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         res_flags_c[FLAG_OVERFLOW]  = 1'b1;
         res_flags_c[FLAG_INEXACT]   = 1'b1;
      end else if (tiny && FTZ != 0) begin
         res_c                       = {sign2, {(EXP_W+MAN_W){1'b0}}};
         res_flags_c[FLAG_UNDERFLOW] = 1'b1;
         res_flags_c[FLAG_INEXACT]   = 1'b1;
      end else begin
         res_flags_c[FLAG_UNDERFLOW] = tiny & inexact;
         res_flags_c[FLAG_INEXACT]   = inexact;
      end
   end

   // Output register: result words only update when a real result arrives
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         d         <= '0;
         out_tag   <= '0;
         flags     <= '0;
      end else if (en) begin
         out_valid <= v2;
         if (v2) begin
            d       <= res_c;
            out_tag <= tag2;
            flags   <= res_flags_c;
         end
      end
   end

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe: flush-to-zero and gradual-underflow instances side by side.
`timescale 1ns/1ps
module tb_fmul_pipe;

   localparam int W     = 32;
   localparam int TAG_W = 4;
   localparam int NV    = 16;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d_ftz;
      logic [3:0]  f_ftz;
      logic [31:0] d_grad;
      logic [3:0]  f_grad;
   } vec_t;

   logic             clk, rstn;
   logic             in_valid, in_ready, g_in_ready;
   logic [W-1:0]     s, t;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid, g_out_valid, out_ready;
   logic [W-1:0]     d, g_d;
   logic [TAG_W-1:0] out_tag, g_out_tag;
   logic [3:0]       flags, g_flags;

   int   n_compared;
   int   n_mismatched;
   vec_t vecs [NV];

   fmul_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(1), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .s(s), .t(t), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .d(d), .out_tag(out_tag), .flags(flags)
   );

   fmul_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(0), .TAG_W(TAG_W)) dut_grad (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(g_in_ready),
      .s(s), .t(t), .in_tag(in_tag), .out_valid(g_out_valid), .out_ready(out_ready),
      .d(g_d), .out_tag(g_out_tag), .flags(g_flags)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop if something hangs
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Present one operand pair for one cycle (out_ready held high, so it is accepted)
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
      @(negedge clk);
      in_valid = 1'b1;
      s        = a;
      t        = b;
      in_tag   = tag;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count cycles from the accept cycle until out_valid, bounded
   task automatic waitResult(output int lat);
      lat = 1;
      while (!out_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic runStream();
      logic [31:0] ops  [8];
      logic [31:0] exps [8];
      logic [3:0]  pat;
      logic [31:0] hold_d;
      logic [3:0]  hold_tag;
      logic        hold_pending, accept, extra;
      int          sent, got;
      ops  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      exps = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
               32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
      pat          = 4'b1001;
      sent         = 0;
      got          = 0;
      hold_pending = 1'b0;
      hold_d       = '0;
      hold_tag     = '0;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
         @(negedge clk);
         if (hold_pending) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_d", d, hold_d);
            checkOutput("stall_tag", 32'(out_tag), 32'(hold_tag));
            hold_pending = 1'b0;
         end
         out_ready = pat[cyc % 4];
         in_valid  = (sent < 8);
         if (sent < 8) begin
            s      = ops[sent];
            t      = 32'h40000000;
            in_tag = 4'(sent);
         end
         #1;
         accept = in_valid && in_ready;
         if (out_valid && out_ready) begin
            checkOutput($sformatf("stream_tag%0d", got), 32'(out_tag), 32'(got));
            checkOutput($sformatf("stream_d%0d", got), d, exps[got]);
            got++;
         end else if (out_valid) begin
            hold_pending = 1'b1;
            hold_d       = d;
            hold_tag     = out_tag;
         end
         if (accept) begin
            sent++;
         end
      end
      checkOutput("stream_count", 32'(got), 32'd8);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      extra     = 1'b0;
      repeat (6) begin
         @(negedge clk);
         extra = extra | out_valid;
      end
      checkOutput("stream_no_extra", 32'(extra), 32'd0);
   endtask

   initial begin
      int   lat;
      logic stale;
      n_compared   = 0;
      n_mismatched = 0;

      vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, 32'h40C00000, 4'b0000};
      vecs[1]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 32'h7F800000, 4'b0101};
      vecs[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 32'h7FC00000, 4'b1000};
      vecs[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 32'h3F800002, 4'b0001};
      vecs[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 32'h00400000, 4'b0000};
      vecs[5]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 32'hC0C00000, 4'b0000};
      vecs[6]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 32'hFF800000, 4'b0000};
      vecs[7]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 32'h80000000, 4'b0000};
      vecs[8]  = '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 32'h7FC00000, 4'b1000};
      vecs[9]  = '{32'hFFC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 32'h7FC00000, 4'b0000};
      vecs[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 32'h00000001, 4'b0000};
      vecs[11] = '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001, 32'h3FC00002, 4'b0001};
      vecs[12] = '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'b0001, 32'h40000000, 4'b0001};
      vecs[13] = '{32'h7F000001, 32'h3FFFFFFE, 32'h7F800000, 4'b0101, 32'h7F800000, 4'b0101};
      vecs[14] = '{32'h00800001, 32'h3F000000, 32'h00000000, 4'b0011, 32'h00400000, 4'b0011};
      vecs[15] = '{32'h00400000, 32'h40000000, 32'h00000000, 4'b0000, 32'h00800000, 4'b0000};

      rstn      = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      s         = '0;
      t         = '0;
      in_tag    = '0;
      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_d", d, 32'd0);
      checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
      checkOutput("rst_flags", 32'(flags), 32'd0);
      checkOutput("rst_g_out_valid", 32'(g_out_valid), 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

      $display("[TB] directed vectors");
      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, 4'(i));
         waitResult(lat);
         checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
         checkOutput($sformatf("v%0d_d", i), d, vecs[i].d_ftz);
         checkOutput($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].f_ftz));
         checkOutput($sformatf("v%0d_tag", i), 32'(out_tag), 32'(i));
         checkOutput($sformatf("v%0d_g_valid", i), 32'(g_out_valid), 32'd1);
         checkOutput($sformatf("v%0d_g_d", i), g_d, vecs[i].d_grad);
         checkOutput($sformatf("v%0d_g_flags", i), 32'(g_flags), 32'(vecs[i].f_grad));
      end

      $display("[TB] streaming with back-pressure");
      runStream();

      $display("[TB] reset with operations in flight");
      @(negedge clk);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         s        = 32'h40000000;
         t        = 32'h40400000;
         in_tag   = 4'(8 + k);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checkOutput("inflight_valid", 32'(out_valid), 32'd1);
      #2 rstn = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("async_rst_g_valid", 32'(g_out_valid), 32'd0);
      checkOutput("async_rst_d", d, 32'd0);
      checkOutput("async_rst_tag", 32'(out_tag), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      checkOutput("rerst_in_ready", 32'(in_ready), 32'd1);
      stale = 1'b0;
      repeat (8) begin
         @(negedge clk);
         stale = stale | out_valid | g_out_valid;
      end
      checkOutput("no_stale_result", 32'(stale), 32'd0);

      applyStimulus(32'h3F800001, 32'h3FFFFFFE, 4'd5);
      waitResult(lat);
      checkOutput("after_rst_latency", 32'(lat), 32'd3);
      checkOutput("after_rst_d", d, 32'h40000000);
      checkOutput("after_rst_tag", 32'(out_tag), 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/fmul_pipe.md
FMUL_PIPE -- requirements
Module: fmul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter FTZ, default 1: 1 = subnormal inputs read as signed zero and tiny results flushed; 0 = full gradual underflow.
REQ-004 SHALL have parameter TAG_W, default 4, width of the pass-through tag.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  operand pair present.
REQ-008 in_ready  out  1  pipeline accepts operands this cycle.
REQ-009 s, t  in  W each  IEEE-style operands.
REQ-010 in_tag  in  TAG_W  opaque tag, returned with the result.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 d  out  W  product.
REQ-014 out_tag  out  TAG_W  tag of this result.
REQ-015 flags  out  4  {invalid, overflow, underflow, inexact} for this result.

Function
REQ-016 SHALL be a 3-stage pipeline: S1 unpack/classify/exponent sum, S2 (MAN_W+1)x(MAN_W+1) multiply, S3 normalise/round/pack; latency 3 cycles from accept to out_valid with no stall.
REQ-017 Transfer in occurs on in_valid&&in_ready; transfer out occurs on out_valid&&out_ready.
REQ-018 Global advance en = !out_valid || out_ready; in_ready SHALL equal en; when en=0 all stage registers hold.
REQ-019 Empty stages SHALL carry valid=0 (bubbles); throughput 1 result/cycle with out_ready held 1.
REQ-020 d, out_tag, flags SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Sign = s.sign XOR t.sign for all non-NaN results, including zero and infinity.
REQ-022 Exponent sum SHALL be computed in EXP_W+2-bit signed arithmetic; biased result = es+et-bias (+1 on product carry), bias = 2^(EXP_W-1)-1; subnormal inputs use exponent 1 and leading-zero normalisation of the product.
REQ-023 Rounding SHALL be round-to-nearest-even using guard, round, sticky over the full 2(MAN_W+1)-bit product; mantissa overflow from rounding increments the exponent.
REQ-024 Any NaN operand, or zero x infinity, SHALL give canonical quiet NaN (sign 0, exponent all ones, MSB of mantissa 1, rest 0); invalid=1 only for zero x infinity or signalling NaN.
REQ-025 Infinity x non-zero finite SHALL give signed infinity, no flags.
REQ-026 Biased exponent >= all-ones after rounding SHALL give signed infinity, overflow=1, inexact=1.
REQ-027 FTZ=1: result below minimum normal (before rounding) SHALL give signed zero, underflow=1, inexact=1.
REQ-028 FTZ=0: tiny results SHALL be right-shifted into subnormal form (shift saturated at MAN_W+2, shifted-out bits folded into sticky) then rounded; underflow=1 only if tiny and inexact.
REQ-029 inexact SHALL be 1 whenever guard|round|sticky is non-zero or the result was flushed or overflowed.
REQ-030 Zero x finite SHALL give signed zero, no flags.

Reset
REQ-031 rstn=0 SHALL asynchronously clear all stage valid bits; out_valid=0, d=0, out_tag=0, flags=0.
REQ-032 in_ready SHALL be 1 from the first edge after rstn deasserts.
REQ-033 Operations in flight at reset assertion SHALL be discarded, never emitted.

Structure
REQ-034 Package fpu_pkg SHALL hold bias computation, the flags bit-index constants, canonical-NaN constant function, and the operand-class enum {ZERO, SUB, NORM, INF, QNAN, SNAN}.
REQ-035 Sub-module fpu_classify (combinational, parametrised by EXP_W/MAN_W) SHALL be instantiated twice in S1.
REQ-036 Rounding/normalisation SHALL stay inline in S3; no further sub-modules.

Verification
REQ-037 0x40000000 x 0x40400000, out_ready=1 -> d=0x40C00000, flags=0, out_valid exactly 3 cycles after accept.
REQ-038 0x7F7FFFFF x 0x40000000 -> d=0x7F800000, flags=0101; 0x7F800000 x 0x00000000 -> d=0x7FC00000, flags=1000.
REQ-039 0x3F800001 x 0x3F800001 -> d=0x3F800002, inexact=1 only.
REQ-040 0x00800000 x 0x3F000000: FTZ=1 -> 0x00000000, flags=0011; FTZ=0 -> 0x00400000, flags=0000.
REQ-041 Stream 8 ops with tags 0..7, out_ready toggling 1,0,0,1 -> all 8 results in tag order, none lost/duplicated, d stable during stall.
REQ-042 Assert rstn=0 with 3 ops in flight -> out_valid=0 immediately; after release no stale result appears.
